// File: rtl/read_bus_sink_pkg.sv
// read_bus_sink_pkg: micro-instruction encodings, destination map codes and handshake state type.
package read_bus_sink_pkg;
  typedef enum logic [2:0] {
    MT_MOVE = 3'd0,
    MT_ALU  = 3'd1,
    MT_NOP  = 3'd2,
    MT_CBR  = 3'd3,
    MT_JMP  = 3'd4
  } mtype_t;
  localparam int A_REG_MAP       = 0;
  localparam int B_REG_MAP       = 1;
  localparam int REG_SEL_MAP     = 2;
  localparam int REG_WR_DATA_MAP = 3;
  localparam int M_PC_MAP        = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2
  } rf_state_t;
endpackage

// File: rtl/read_bus_sink_rf_handshake.sv
// rf_handshake: register-file request FSM with a bounded wait for rf_ack.
module rf_handshake
  import read_bus_sink_pkg::*;
#(
  parameter int RF_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start_wr,
  input  logic start_rd,
  input  logic rf_ack,
  output logic rf_wr_en,
  output logic rf_rd_en,
  output logic busy,
  output logic timeout
);
  rf_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic expired;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // The final waiting cycle is the one where the count equals RF_TIMEOUT-1.
  always_comb begin
    expired = cnt_q == 8'(RF_TIMEOUT - 1);
    state_d = state_q;
    if (state_q == IDLE)
      state_d = start_wr ? WR_REQ : start_rd ? RD_REQ : IDLE;
    else if (rf_ack || expired)
      state_d = IDLE;
    cnt_d = (state_q == IDLE || rf_ack || expired) ? 8'd0 : cnt_q + 8'd1;
  end
  always_comb begin
    rf_wr_en = state_q == WR_REQ;
    rf_rd_en = state_q == RD_REQ;
    busy     = state_q != IDLE;
    timeout  = busy && !rf_ack && expired;
  end
endmodule

// File: rtl/read_bus_sink.sv
// read_bus_sink: latches the producer bus into the selected datapath register and sequences the micro-PC.
module read_bus_sink
  import read_bus_sink_pkg::*;
#(
  parameter int WRITE_WIDTH = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int MPC_WIDTH   = 8,
  parameter int SEL_WIDTH   = 4,
  parameter int RF_TIMEOUT  = 15
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   minstr_valid,
  input  logic [2:0]             minstr_type,
  input  logic [ADDR_WIDTH-1:0]  reg_dst,
  input  logic [WRITE_WIDTH-1:0] write_bus_in,
  output logic                   stall,
  output logic [WRITE_WIDTH-1:0] a_reg,
  output logic [WRITE_WIDTH-1:0] b_reg,
  output logic [SEL_WIDTH-1:0]   reg_sel,
  output logic [WRITE_WIDTH-1:0] reg_wr_data,
  output logic                   rf_wr_en,
  output logic                   rf_rd_en,
  input  logic                   rf_ack,
  output logic [MPC_WIDTH-1:0]   m_pc,
  output logic                   bus_err
);
  logic [WRITE_WIDTH-1:0] a_q, a_d, b_q, b_d, wd_q, wd_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [MPC_WIDTH-1:0]   pc_q, pc_d;
  logic                   err_q, err_d;
  logic accept, mv, dst_a, dst_b, dst_sel, dst_wd, dst_pc, dst_bad, rsvd, ld_pc;
  logic start_wr, start_rd, busy, timeout;
  rf_handshake #(.RF_TIMEOUT(RF_TIMEOUT)) u_hs (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .start_wr(start_wr),
    .start_rd(start_rd),
    .rf_ack  (rf_ack),
    .rf_wr_en(rf_wr_en),
    .rf_rd_en(rf_rd_en),
    .busy    (busy),
    .timeout (timeout)
  );
  always_comb begin
    stall    = busy;
    accept   = minstr_valid && !busy;
    mv       = accept && minstr_type == MT_MOVE;
    dst_a    = reg_dst == ADDR_WIDTH'(A_REG_MAP);
    dst_b    = reg_dst == ADDR_WIDTH'(B_REG_MAP);
    dst_sel  = reg_dst == ADDR_WIDTH'(REG_SEL_MAP);
    dst_wd   = reg_dst == ADDR_WIDTH'(REG_WR_DATA_MAP);
    dst_pc   = reg_dst == ADDR_WIDTH'(M_PC_MAP);
    dst_bad  = !(dst_a || dst_b || dst_sel || dst_wd || dst_pc);
    rsvd     = minstr_type > MT_JMP;
    ld_pc    = (mv && dst_pc) || minstr_type == MT_CBR || minstr_type == MT_JMP;
    start_wr = mv && dst_wd;
    start_rd = mv && dst_sel;
    a_d      = mv && dst_a ? write_bus_in : a_q;
    b_d      = mv && dst_b ? write_bus_in : b_q;
    sel_d    = start_rd ? write_bus_in[SEL_WIDTH-1:0] : sel_q;
    wd_d     = start_wr ? write_bus_in : wd_q;
    pc_d     = !accept ? pc_q : ld_pc ? write_bus_in[MPC_WIDTH-1:0] : pc_q + MPC_WIDTH'(1);
    err_d    = err_q || timeout || (mv && dst_bad) || (accept && rsvd);
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
      wd_q  <= '0;
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      sel_q <= sel_d;
      wd_q  <= wd_d;
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end
  assign a_reg       = a_q;
  assign b_reg       = b_q;
  assign reg_sel     = sel_q;
  assign reg_wr_data = wd_q;
  assign m_pc        = pc_q;
  assign bus_err     = err_q;
endmodule
